// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares a single memory port between instruction fetch and
//                data accesses. Data has priority, one transaction in flight,
//                with a timeout abort.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_fetch_req,
    input  logic [DATA_WIDTH-1:0] i_pc_IF,
    output logic [DATA_WIDTH-1:0] o_instr_ID,
    output logic                  o_instr_valid,
    input  logic                  i_data_req,
    input  logic                  i_mem_write_M,
    input  logic [DATA_WIDTH-1:0] i_data_addr_M,
    input  logic [DATA_WIDTH-1:0] i_write_data_M,
    output logic [DATA_WIDTH-1:0] o_read_data_M,
    output logic                  o_data_valid,
    output logic                  o_stall,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [DATA_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    input  logic                  i_mem_ack,
    output logic                  o_bus_err
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_data  = 2'd1;
    localparam logic [1:0] c_st_fetch = 2'd2;

    // Counter value seen on the last busy cycle before an abort.
    localparam logic [7:0] c_wait_last = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0] r_state;
    logic [7:0] r_wait_cnt;

    logic w_data_pending;
    logic w_fetch_pending;
    logic w_busy;
    logic w_timeout;

    // A request whose valid is showing this cycle has just been served and
    // must not be granted again.
    assign w_data_pending  = i_data_req & ~o_data_valid;
    assign w_fetch_pending = i_fetch_req & ~o_instr_valid;
    assign o_stall         = w_fetch_pending | w_data_pending;

    assign w_busy    = (r_state == c_st_data) || (r_state == c_st_fetch);
    assign w_timeout = w_busy & ~i_mem_ack & (r_wait_cnt == c_wait_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_wait_cnt    <= 8'd0;
            o_mem_req     <= 1'b0;
            o_mem_we      <= 1'b0;
            o_mem_addr    <= '0;
            o_mem_wdata   <= '0;
            o_instr_ID    <= '0;
            o_read_data_M <= '0;
            o_instr_valid <= 1'b0;
            o_data_valid  <= 1'b0;
            o_bus_err     <= 1'b0;
        end else begin
            o_instr_valid <= 1'b0;
            o_data_valid  <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_data_pending) begin
                        r_state     <= c_st_data;
                        r_wait_cnt  <= 8'd0;
                        o_mem_req   <= 1'b1;
                        o_mem_we    <= i_mem_write_M;
                        o_mem_addr  <= i_data_addr_M;
                        o_mem_wdata <= i_write_data_M;
                    end else if (w_fetch_pending) begin
                        r_state     <= c_st_fetch;
                        r_wait_cnt  <= 8'd0;
                        o_mem_req   <= 1'b1;
                        o_mem_we    <= 1'b0;
                        o_mem_addr  <= i_pc_IF;
                        o_mem_wdata <= '0;
                    end
                end
                c_st_data, c_st_fetch: begin
                    if (i_mem_ack || w_timeout) begin
                        // An abort completes the access with zero data.
                        r_state   <= c_st_idle;
                        o_mem_req <= 1'b0;
                        if (r_state == c_st_data) begin
                            o_read_data_M <= i_mem_ack ? i_mem_rdata : '0;
                            o_data_valid  <= 1'b1;
                        end else begin
                            o_instr_ID    <= i_mem_ack ? i_mem_rdata : '0;
                            o_instr_valid <= 1'b1;
                        end
                        if (!i_mem_ack) begin
                            o_bus_err <= 1'b1;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state   <= c_st_idle;
                    o_mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Random core/memory traffic against a transaction-level model
//                of the arbiter, including mid-transaction resets.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int c_timeout = 4;
    localparam int c_cycles  = 4000;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_fetch_req;
    logic [31:0] i_pc_IF;
    logic [31:0] o_instr_ID;
    logic        o_instr_valid;
    logic        i_data_req;
    logic        i_mem_write_M;
    logic [31:0] i_data_addr_M;
    logic [31:0] i_write_data_M;
    logic [31:0] o_read_data_M;
    logic        o_data_valid;
    logic        o_stall;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;
    logic        i_mem_ack;
    logic        o_bus_err;

    mem_port_arbiter #(
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (c_timeout)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .i_fetch_req    (i_fetch_req),
        .i_pc_IF        (i_pc_IF),
        .o_instr_ID     (o_instr_ID),
        .o_instr_valid  (o_instr_valid),
        .i_data_req     (i_data_req),
        .i_mem_write_M  (i_mem_write_M),
        .i_data_addr_M  (i_data_addr_M),
        .i_write_data_M (i_write_data_M),
        .o_read_data_M  (o_read_data_M),
        .o_data_valid   (o_data_valid),
        .o_stall        (o_stall),
        .o_mem_req      (o_mem_req),
        .o_mem_we       (o_mem_we),
        .o_mem_addr     (o_mem_addr),
        .o_mem_wdata    (o_mem_wdata),
        .i_mem_rdata    (i_mem_rdata),
        .i_mem_ack      (i_mem_ack),
        .o_bus_err      (o_bus_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected visible outputs for the current cycle.
    logic        exp_req, exp_we, exp_iv, exp_dv, exp_err;
    logic [31:0] exp_addr, exp_wdata, exp_instr, exp_rdata;
    // Transaction in flight: kind, busy-cycle index, chosen ack delay.
    bit          m_busy, m_is_data;
    int          m_k, m_d;
    bit          want_rst;

    task automatic model_reset();
        exp_req   = 1'b0; exp_we = 1'b0; exp_iv = 1'b0; exp_dv = 1'b0; exp_err = 1'b0;
        exp_addr  = '0;   exp_wdata = '0; exp_instr = '0; exp_rdata = '0;
        m_busy    = 1'b0; m_is_data = 1'b0; m_k = 0; m_d = 0;
    endtask

    task automatic check_outputs();
        check("stall", 32'((i_fetch_req & ~exp_iv) | (i_data_req & ~exp_dv)), 32'(o_stall) ^ 32'(0));
        check("mem_req", 32'(o_mem_req), 32'(exp_req));
        if (exp_req) begin
            check("mem_addr", o_mem_addr, exp_addr);
            check("mem_we", 32'(o_mem_we), 32'(exp_we));
            check("mem_wdata", o_mem_wdata, exp_wdata);
        end
        check("instr_valid", 32'(o_instr_valid), 32'(exp_iv));
        check("data_valid", 32'(o_data_valid), 32'(exp_dv));
        check("instr_ID", o_instr_ID, exp_instr);
        check("read_data", o_read_data_M, exp_rdata);
        check("bus_err", 32'(o_bus_err), 32'(exp_err));
    endtask

    task automatic new_data();
        i_data_addr_M  = $urandom;
        i_write_data_M = $urandom;
        i_mem_write_M  = 1'($urandom_range(0, 1));
    endtask

    // Core behaviour: hold a request until its valid, then drop it or present
    // a fresh one; scramble fields of a request already being served.
    task automatic drive_core();
        if (i_data_req) begin
            if (exp_dv) begin
                if ($urandom_range(0, 1) == 0) i_data_req = 1'b0;
                else new_data();
            end else if (m_busy && m_is_data) begin
                new_data();
            end
        end else if ($urandom_range(0, 3) == 0) begin
            i_data_req = 1'b1;
            new_data();
        end
        if (i_fetch_req) begin
            if (exp_iv) begin
                if ($urandom_range(0, 1) == 0) i_fetch_req = 1'b0;
                else i_pc_IF = $urandom;
            end else if (m_busy && !m_is_data) begin
                i_pc_IF = $urandom;
            end
        end else if ($urandom_range(0, 2) == 0) begin
            i_fetch_req = 1'b1;
            i_pc_IF     = $urandom;
        end
    endtask

    // Memory answers d cycles after the request appears; spurious acks when idle.
    task automatic drive_mem();
        i_mem_rdata = $urandom;
        if (m_busy) i_mem_ack = (m_k == m_d + 1);
        else        i_mem_ack = ($urandom_range(0, 7) == 0);
    endtask

    task automatic complete(input logic [31:0] value);
        exp_req = 1'b0;
        m_busy  = 1'b0;
        if (m_is_data) begin exp_rdata = value; exp_dv = 1'b1; end
        else           begin exp_instr = value; exp_iv = 1'b1; end
    endtask

    task automatic grant(input bit is_data, input logic [31:0] addr, input logic we, input logic [31:0] wdata);
        exp_req   = 1'b1;
        exp_addr  = addr;
        exp_we    = we;
        exp_wdata = wdata;
        m_busy    = 1'b1;
        m_is_data = is_data;
        m_k       = 1;
        m_d       = $urandom_range(0, c_timeout + 1);
    endtask

    // Advance expectations across the next rising edge.
    task automatic model_step();
        bit cur_iv;
        bit cur_dv;
        cur_iv = exp_iv;
        cur_dv = exp_dv;
        exp_iv = 1'b0;
        exp_dv = 1'b0;
        if (m_busy) begin
            if (i_mem_ack) begin
                complete(i_mem_rdata);
            end else if (m_k == c_timeout) begin
                complete(32'h0);
                exp_err = 1'b1;
            end else begin
                m_k++;
            end
        end else if (i_data_req && !cur_dv) begin
            grant(1'b1, i_data_addr_M, i_mem_write_M, i_write_data_M);
        end else if (i_fetch_req && !cur_iv) begin
            grant(1'b0, i_pc_IF, 1'b0, 32'h0);
        end
    endtask

    // Reset in the middle of a transaction, then a late ack after release.
    task automatic do_reset();
        #2;
        rst         = 1'b1;
        i_data_req  = 1'b0;
        i_fetch_req = 1'b0;
        i_mem_ack   = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        rst         = 1'b0;
        i_mem_ack   = 1'b1;
        i_mem_rdata = $urandom;
    endtask

    initial begin
        rst            = 1'b1;
        i_fetch_req    = 1'b0;
        i_pc_IF        = '0;
        i_data_req     = 1'b0;
        i_mem_write_M  = 1'b0;
        i_data_addr_M  = '0;
        i_write_data_M = '0;
        i_mem_rdata    = '0;
        i_mem_ack      = 1'b0;
        want_rst       = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs();
        rst = 1'b0;

        for (int cyc = 0; cyc < c_cycles; cyc++) begin
            if (cyc % 1000 == 999) want_rst = 1'b1;
            if (want_rst && m_busy) begin
                do_reset();
                want_rst = 1'b0;
            end else begin
                drive_core();
                drive_mem();
                model_step();
            end
            @(posedge clk);
            @(negedge clk);
            check_outputs();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
